read_capture_fsm: RTL and testbench

Read-path counterpart of the DDR5 PHY write FSM. It sits between the DRAM DQ/DQS pins (already deserialised to the PHY clock) and the frequency-ratio block toward the MC. On a read command it waits out read latency, checks the DQS read preamble, and captures the data burst. It returns captured data to the MC with a valid strobe, and checks the DRAM read CRC when the optional feature is compiled in.

---
 rtl/read_capture_fsm.sv | 190 +++++++++++++++++++
 tb/tb_read_capture_fsm.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/read_capture_fsm.sv
// DDR5 PHY read capture: waits read latency, checks DQS preamble, captures the DQ burst.
// Define RD_CRC_CHECK_EN to add the CRC_PAD/CRC states and the read CRC comparison.
module read_capture_fsm #(
    parameter int unsigned N       = 4,
    parameter int unsigned PRE_CYC = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic             i_rd_en,
    input  logic [5:0]       i_rl,
    input  logic [1:0]       i_burstlength,
    input  logic [1:0]       i_DQS,
    input  logic [2*N-1:0]   i_DQ,
    input  logic [2*N-1:0]   i_crc_code,
    output logic [2*N-1:0]   o_rddata,
    output logic             o_rddata_valid,
    output logic [2*N-1:0]   o_crc_data,
    output logic             o_crc_enable,
    output logic             o_crc_error,
    output logic             o_preamble_err,
    output logic             o_cmd_overflow,
    output logic             o_busy,
    output logic             o_rd_done
);

    localparam int unsigned W = 2 * N;
`ifdef RD_CRC_CHECK_EN
    localparam bit CrcEn = 1'b1;
`else
    localparam bit CrcEn = 1'b0;
`endif
    localparam logic [2:0] PreLast = 3'(PRE_CYC - 1);

    typedef enum logic [2:0] {
        StIdle, StWaitRl, StPreamble, StData, StCrcPad, StCrc, StPostamble
    } state_e;

    state_e         r_state, w_state_d;
    logic [5:0]     r_lat_cnt, w_lat_d;
    logic [2:0]     r_pre_cnt, w_pre_d;
    logic [2:0]     r_beat_cnt, w_beat_d;
    logic           r_bl8, w_bl8_d;
    logic [W-1:0]   r_rddata;
    logic           r_valid, w_valid_d;
    logic           r_pre_err, w_pre_err_d;
    logic           r_crc_err, w_crc_err_d;
    logic           r_ovf, w_ovf_d;
    logic           r_done, w_done_d;
    logic [1:0]     w_dqs_exp;
    logic [2:0]     w_beat_last;
    logic [W-1:0]   w_crc_data;
    logic           w_crc_en;

    assign w_dqs_exp   = (r_pre_cnt == PreLast) ? 2'b10 : 2'b00;
    assign w_beat_last = r_bl8 ? 3'd3 : 3'd7;

    always_comb begin
        w_state_d   = r_state;
        w_lat_d     = r_lat_cnt;
        w_pre_d     = r_pre_cnt;
        w_beat_d    = r_beat_cnt;
        w_bl8_d     = r_bl8;
        w_valid_d   = 1'b0;
        w_pre_err_d = 1'b0;
        w_crc_err_d = 1'b0;
        w_done_d    = 1'b0;
        w_ovf_d     = i_rd_en && (r_state != StIdle);
        case (r_state)
            StIdle: begin
                if (i_rd_en) begin
                    w_bl8_d   = (i_burstlength == 2'b01);
                    w_lat_d   = i_rl;
                    w_pre_d   = '0;
                    w_beat_d  = '0;
                    w_state_d = (i_rl <= 6'd1) ? StPreamble : StWaitRl;
                end
            end
            StWaitRl: begin
                // Leave one cycle early so the first preamble sample lands at t+i_rl.
                w_lat_d = r_lat_cnt - 6'd1;
                if (r_lat_cnt <= 6'd2) begin
                    w_state_d = StPreamble;
                end
            end
            StPreamble: begin
                if (i_DQS != w_dqs_exp) begin
                    w_pre_err_d = 1'b1;
                    w_state_d   = StIdle;
                end else if (r_pre_cnt == PreLast) begin
                    w_pre_d   = '0;
                    w_state_d = StData;
                end else begin
                    w_pre_d = r_pre_cnt + 3'd1;
                end
            end
            StData: begin
                w_valid_d = 1'b1;
                if (r_beat_cnt == w_beat_last) begin
                    w_beat_d = '0;
                    if (CrcEn) begin
                        w_state_d = r_bl8 ? StCrcPad : StCrc;
                    end else begin
                        w_state_d = StPostamble;
                    end
                end else begin
                    w_beat_d = r_beat_cnt + 3'd1;
                end
            end
            StCrcPad: begin
                if (r_beat_cnt == 3'd3) begin
                    w_beat_d  = '0;
                    w_state_d = StCrc;
                end else begin
                    w_beat_d = r_beat_cnt + 3'd1;
                end
            end
            StCrc: begin
                w_crc_err_d = (i_DQ != i_crc_code);
                w_state_d   = StPostamble;
            end
            StPostamble: begin
                w_done_d  = 1'b1;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_lat_cnt  <= '0;
            r_pre_cnt  <= '0;
            r_beat_cnt <= '0;
            r_bl8      <= 1'b0;
            r_rddata   <= '0;
            r_valid    <= 1'b0;
            r_pre_err  <= 1'b0;
            r_crc_err  <= 1'b0;
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
        end else if (!i_enable) begin
            r_valid   <= 1'b0;
            r_pre_err <= 1'b0;
            r_crc_err <= 1'b0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_lat_cnt  <= w_lat_d;
            r_pre_cnt  <= w_pre_d;
            r_beat_cnt <= w_beat_d;
            r_bl8      <= w_bl8_d;
            r_valid    <= w_valid_d;
            r_pre_err  <= w_pre_err_d;
            r_crc_err  <= w_crc_err_d;
            r_ovf      <= w_ovf_d;
            r_done     <= w_done_d;
            if (r_state == StData) begin
                r_rddata <= i_DQ;
            end
        end
    end

    always_comb begin
        w_crc_data = '0;
        w_crc_en   = 1'b0;
        if (CrcEn && i_enable) begin
            if (r_state == StData) begin
                w_crc_data = i_DQ;
                w_crc_en   = 1'b1;
            end else if (r_state == StCrcPad) begin
                w_crc_data = '1;
                w_crc_en   = 1'b1;
            end
        end
    end

    assign o_rddata       = r_rddata;
    assign o_rddata_valid = r_valid & i_enable;
    assign o_crc_data     = w_crc_data;
    assign o_crc_enable   = w_crc_en;
    assign o_crc_error    = r_crc_err & i_enable & CrcEn;
    assign o_preamble_err = r_pre_err & i_enable;
    assign o_cmd_overflow = r_ovf & i_enable;
    assign o_busy         = (r_state != StIdle);
    assign o_rd_done      = r_done & i_enable;

endmodule

// File: tb/tb_read_capture_fsm.sv
// Directed-vector bench for read_capture_fsm; follows RD_CRC_CHECK_EN like the design.
`timescale 1ns/1ps
module tb_read_capture_fsm;

    localparam int N   = 4;
    localparam int PRE = 2;
`ifdef RD_CRC_CHECK_EN
    localparam bit CRC = 1'b1;
`else
    localparam bit CRC = 1'b0;
`endif

    logic       clk, rst, enable, rd_en;
    logic [5:0] rl;
    logic [1:0] bl, dqs;
    logic [7:0] dq, crc_code;
    logic [7:0] rddata, crc_data;
    logic       rddata_valid, crc_enable, crc_error, preamble_err, cmd_overflow, busy, rd_done;

    read_capture_fsm #(.N(N), .PRE_CYC(PRE)) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_rd_en(rd_en), .i_rl(rl),
        .i_burstlength(bl), .i_DQS(dqs), .i_DQ(dq), .i_crc_code(crc_code),
        .o_rddata(rddata), .o_rddata_valid(rddata_valid), .o_crc_data(crc_data),
        .o_crc_enable(crc_enable), .o_crc_error(crc_error), .o_preamble_err(preamble_err),
        .o_cmd_overflow(cmd_overflow), .o_busy(busy), .o_rd_done(rd_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rd_en;
        logic [5:0] rl;
        logic [1:0] bl;
        logic [1:0] dqs;
        logic [7:0] dq;
        logic [7:0] code;
        logic       valid;
        logic [7:0] rddata;
        logic       busy;
        logic       done;
        logic       perr;
        logic       ovf;
        logic       cen;
        logic [7:0] cdata;
        logic       cerr;
    } vec_t;

    vec_t q[$];
    int   checks, errors;
    logic p_valid, p_done, p_perr, p_ovf, p_cerr;
    logic [7:0] p_data, last_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Appends one cycle; registered pulses owed from the previous cycle land here.
    task automatic add(input logic r, input logic [5:0] l, input logic [1:0] b, input logic [1:0] s,
                       input logic [7:0] d, input logic [7:0] c, input logic bsy,
                       input logic ce, input logic [7:0] cd);
        vec_t v;
        if (p_valid) last_data = p_data;
        v.rd_en = r;  v.rl = l;  v.bl = b;  v.dqs = s;  v.dq = d;  v.code = c;
        v.valid = p_valid;  v.rddata = last_data;  v.busy = bsy;  v.done = p_done;
        v.perr = p_perr;  v.ovf = p_ovf;  v.cen = ce;  v.cdata = cd;  v.cerr = p_cerr;
        q.push_back(v);
        p_valid = 1'b0; p_done = 1'b0; p_perr = 1'b0; p_cerr = 1'b0;
        p_ovf   = r && bsy;
    endtask

    task automatic burst(input logic [5:0] l, input logic [1:0] b, input logic [7:0] base,
                         input logic [7:0] crc_rx, input logic [7:0] c, input bit ovf_b1,
                         input bit bad_pre);
        int waits, beats;
        logic [7:0] d;
        logic [1:0] s;
        waits = (l <= 6'd1) ? 0 : int'(l) - 1;
        beats = (b == 2'b01) ? 4 : 8;
        add(1'b0, l, b, 2'b00, 8'h00, c, 1'b0, 1'b0, 8'h00);
        add(1'b1, l, b, 2'b00, 8'h00, c, 1'b0, 1'b0, 8'h00);
        // After the command, rl/bl inputs are scrambled; the latched values must rule.
        for (int i = 0; i < waits; i++) add(1'b0, 6'h3f, b ^ 2'b01, 2'b01, 8'h00, c, 1'b1, 1'b0, 8'h00);
        for (int k = 0; k < PRE; k++) begin
            s = (k == PRE - 1) ? 2'b10 : 2'b00;
            if (bad_pre && k == 0) begin
                add(1'b0, 6'h3f, b ^ 2'b01, 2'b10, 8'h00, c, 1'b1, 1'b0, 8'h00);
                p_perr = 1'b1;
                add(1'b0, l, b, 2'b00, 8'h00, c, 1'b0, 1'b0, 8'h00);
                add(1'b0, l, b, 2'b00, 8'h00, c, 1'b0, 1'b0, 8'h00);
                return;
            end
            add(1'b0, 6'h3f, b ^ 2'b01, s, 8'h00, c, 1'b1, 1'b0, 8'h00);
        end
        for (int i = 0; i < beats; i++) begin
            d = base + 8'(i);
            add(ovf_b1 && i == 1, 6'h3f, b ^ 2'b01, 2'b11, d, c, 1'b1, CRC, CRC ? d : 8'h00);
            p_valid = 1'b1;
            p_data  = d;
        end
        if (CRC && b == 2'b01)
            for (int i = 0; i < 4; i++) add(1'b0, l, b, 2'b11, 8'h00, c, 1'b1, 1'b1, 8'hFF);
        if (CRC) begin
            add(1'b0, l, b, 2'b11, crc_rx, c, 1'b1, 1'b0, 8'h00);
            p_cerr = (crc_rx != c);
        end
        add(1'b0, l, b, 2'b11, 8'h00, c, 1'b1, 1'b0, 8'h00);
        p_done = 1'b1;
        add(1'b0, l, b, 2'b00, 8'h00, c, 1'b0, 1'b0, 8'h00);
        add(1'b0, l, b, 2'b00, 8'h00, c, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic run_vectors(input string tag);
        vec_t v;
        for (int i = 0; i < q.size(); i++) begin
            v = q[i];
            rd_en = v.rd_en; rl = v.rl; bl = v.bl; dqs = v.dqs; dq = v.dq; crc_code = v.code;
            @(negedge clk);
            chk($sformatf("%s[%0d] valid", tag, i), rddata_valid, v.valid);
            chk($sformatf("%s[%0d] rddata", tag, i), rddata, v.rddata);
            chk($sformatf("%s[%0d] busy", tag, i), busy, v.busy);
            chk($sformatf("%s[%0d] done", tag, i), rd_done, v.done);
            chk($sformatf("%s[%0d] pre_err", tag, i), preamble_err, v.perr);
            chk($sformatf("%s[%0d] overflow", tag, i), cmd_overflow, v.ovf);
            chk($sformatf("%s[%0d] crc_en", tag, i), crc_enable, v.cen);
            chk($sformatf("%s[%0d] crc_data", tag, i), crc_data, v.cdata);
            chk($sformatf("%s[%0d] crc_err", tag, i), crc_error, v.cerr);
            tick();
        end
        q.delete();
    endtask

    function automatic logic [31:0] all_outs();
        return {rddata, rddata_valid, crc_data, crc_enable, crc_error, preamble_err,
                cmd_overflow, busy, rd_done};
    endfunction

    initial begin
        int n;
        bit seen_done;
        checks = 0; errors = 0;
        p_valid = 0; p_done = 0; p_perr = 0; p_ovf = 0; p_cerr = 0; p_data = 0; last_data = 0;
        rst = 1'b1; enable = 1'b1; rd_en = 1'b0; rl = 6'd0; bl = 2'b00;
        dqs = 2'b00; dq = 8'h00; crc_code = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", all_outs(), 32'h0);
        rst = 1'b0;

        burst(6'd5, 2'b00, 8'h01, 8'h5A, 8'h5A, 1'b0, 1'b0);  // rl=5 BL16
        burst(6'd0, 2'b01, 8'hA0, 8'h5A, 8'h5A, 1'b0, 1'b0);  // rl=0 BL8
        burst(6'd3, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);  // bad preamble
        burst(6'd2, 2'b00, 8'h10, 8'h5B, 8'h5A, 1'b0, 1'b0);  // CRC mismatch
        burst(6'd2, 2'b00, 8'h50, 8'h5A, 8'h5A, 1'b0, 1'b0);  // CRC match
        burst(6'd1, 2'b00, 8'h20, 8'h5A, 8'h5A, 1'b1, 1'b0);  // overflow in DATA
        burst(6'd2, 2'b11, 8'h60, 8'h5A, 8'h5A, 1'b0, 1'b0);  // 2'b11 acts as BL16
        run_vectors("main");

        // Enable dropped mid-burst: state freezes, valid masked, rddata holds.
        crc_code = 8'h00; dq = 8'h00;
        rd_en = 1'b1; rl = 6'd2; bl = 2'b00; tick();
        rd_en = 1'b0; tick();
        dqs = 2'b00; tick();
        dqs = 2'b10; tick();
        dqs = 2'b11; dq = 8'h30; tick();
        dq = 8'h31; tick();
        enable = 1'b0; dq = 8'hEE;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("en_low[%0d] valid", i), rddata_valid, 1'b0);
            chk($sformatf("en_low[%0d] rddata", i), rddata, 8'h31);
            chk($sformatf("en_low[%0d] busy", i), busy, 1'b1);
            tick();
        end
        enable = 1'b1;
        n = 0; seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            dq = (i < 6) ? 8'h32 + 8'(i) : 8'h00;
            @(negedge clk);
            if (rddata_valid) begin
                chk($sformatf("en_resume beat%0d", n), rddata, 8'h32 + 8'(n));
                n++;
            end
            if (rd_done) seen_done = 1'b1;
            tick();
        end
        chk("en_resume beat count", n, 6);
        chk("en_resume done seen", seen_done, 1'b1);
        chk("en_resume idle", busy, 1'b0);

        // Reset in the third DATA cycle.
        rd_en = 1'b1; rl = 6'd1; bl = 2'b00; dqs = 2'b00; tick();
        rd_en = 1'b0; tick();
        dqs = 2'b10; tick();
        dqs = 2'b11; dq = 8'h40; tick();
        dq = 8'h41; tick();
        dq = 8'h42;
        @(negedge clk);
        chk("pre_rst busy", busy, 1'b1);
        #1 rst = 1'b1;
        #1 chk("rst mid-burst outputs", all_outs(), 32'h0);
        tick();
        rst = 1'b0; dq = 8'h00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst[%0d] done/busy", i), {rd_done, busy}, 2'b00);
            tick();
        end
        last_data = 8'h00;
        p_valid = 0; p_done = 0; p_perr = 0; p_ovf = 0; p_cerr = 0;
        burst(6'd5, 2'b00, 8'h01, 8'h5A, 8'h5A, 1'b0, 1'b0);
        run_vectors("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
